// File: rtl/host_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_sequencer_pkg : shared FSM state, load-kind encoding and widths  | rev 1.0
// ----------------------------------------------------------------------------
package host_sequencer_pkg;

  localparam int IMEM_AW = 10;
  localparam int IW      = 9;
  localparam int DMEM_AW = 8;
  localparam int DW      = 8;

  localparam logic c_KIND_INSTR = 1'b0;
  localparam logic c_KIND_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/host_seq_wdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_seq_wdog : counts consecutive RUN cycles, flags the TIMEOUT-th one  | rev 1.0
// ----------------------------------------------------------------------------
module host_seq_wdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (run_i) begin
      count_q <= count_q + CW'(1);
    end else begin
      count_q <= '0;
    end
  end

  assign expired_o = run_i && (count_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/host_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// host_sequencer : load imem/dmem, start CPU, stream results back; optional
// RUN timeout under HOST_SEQ_TIMEOUT_EN                                 | rev 1.0
// ----------------------------------------------------------------------------
module host_sequencer
  import host_sequencer_pkg::*;
#(
  parameter int unsigned START_CYCLES = 2,
  parameter logic [7:0]  RESULT_BASE  = 8'd0,
  parameter int unsigned RESULT_LEN   = 4,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_kind,
  input  logic [IW-1:0]      ld_data,
  input  logic               ld_last,
  output logic               imem_wr_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [IW-1:0]      imem_wdata,
  output logic               dmem_wr_en,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DW-1:0]      dmem_wdata,
  input  logic [DW-1:0]      dmem_rd_data,
  output logic               cpu_start,
  input  logic               cpu_done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW-1:0]      rd_data,
  output logic               busy,
  output logic               seq_done,
  output logic               imem_ovf,
  output logic               timeout_err
);

  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCW-1:0]     c_START_LAST = SCW'(START_CYCLES - 1);
  localparam logic [DMEM_AW-1:0] c_IDX_LAST   = DMEM_AW'(RESULT_LEN - 1);

  if (START_CYCLES < 1 || RESULT_LEN < 1 || RESULT_LEN > 256 || TIMEOUT < 1) begin : g_param_check
    $error("host_sequencer: parameter out of range");
  end

  state_t               state_q, state_d;
  logic [IMEM_AW-1:0]   icnt_q;
  logic [DMEM_AW-1:0]   dcnt_q;
  logic [DMEM_AW-1:0]   idx_q;
  logic [SCW-1:0]       start_cnt_q;
  logic                 run_armed_q;
  logic                 ovf_q;
  logic                 imem_wr_q, dmem_wr_q;
  logic [IMEM_AW-1:0]   imem_addr_q;
  logic [IW-1:0]        imem_wdata_q;
  logic [DMEM_AW-1:0]   dmem_addr_q;
  logic [DW-1:0]        dmem_wdata_q;

  logic w_accept, w_fin_exit, w_rd_xfer, w_in_run, w_timeout;

  assign w_accept   = ld_valid && ld_ready;
  assign w_fin_exit = ((state_q == ST_FIN) || (state_q == ST_ERR)) && ld_valid;
  assign w_rd_xfer  = rd_valid && rd_ready;
  assign w_in_run   = (state_q == ST_RUN);

`ifdef HOST_SEQ_TIMEOUT_EN
  host_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (w_in_run),
    .expired_o (w_timeout)
  );
  assign timeout_err = (state_q == ST_ERR);
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_LOAD: if (w_accept) state_d = ld_last ? ST_START : ST_LOAD;
      ST_START:         if (start_cnt_q == c_START_LAST) state_d = ST_RUN;
      ST_RUN: begin
        // cpu_done is only trusted from the second RUN cycle on
        if (run_armed_q && cpu_done) state_d = ST_DRAIN;
        else if (w_timeout)          state_d = ST_ERR;
      end
      ST_DRAIN:         if (w_rd_xfer && (idx_q == c_IDX_LAST)) state_d = ST_FIN;
      ST_FIN, ST_ERR:   if (ld_valid) state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    busy      = 1'b0;
    cpu_start = 1'b0;
    rd_valid  = 1'b0;
    seq_done  = 1'b0;
    rd_data   = '0;
    dmem_addr = dmem_addr_q;
    unique case (state_q)
      ST_IDLE:  ld_ready = 1'b1;
      ST_LOAD:  begin ld_ready = 1'b1; busy = 1'b1; end
      ST_START: begin busy = 1'b1; cpu_start = 1'b1; end
      ST_RUN:   busy = 1'b1;
      ST_DRAIN: begin
        busy      = 1'b1;
        rd_valid  = 1'b1;
        rd_data   = dmem_rd_data;
        dmem_addr = RESULT_BASE + idx_q;
      end
      ST_FIN:   seq_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icnt_q       <= '0;
      dcnt_q       <= '0;
      ovf_q        <= 1'b0;
      imem_wr_q    <= 1'b0;
      dmem_wr_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      imem_wr_q <= w_accept && (ld_kind == c_KIND_INSTR);
      dmem_wr_q <= w_accept && (ld_kind == c_KIND_DATA);
      if (w_fin_exit) begin
        icnt_q <= '0;
        dcnt_q <= '0;
        ovf_q  <= 1'b0;
      end else if (w_accept) begin
        if (ld_kind == c_KIND_INSTR) begin
          imem_addr_q  <= icnt_q;
          imem_wdata_q <= ld_data;
          icnt_q       <= icnt_q + 1'b1;
          if (icnt_q == '1) ovf_q <= 1'b1;
        end else begin
          dmem_addr_q  <= dcnt_q;
          dmem_wdata_q <= ld_data[DW-1:0];
          dcnt_q       <= dcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_cnt_q <= '0;
      run_armed_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      start_cnt_q <= (state_q == ST_START) ? start_cnt_q + 1'b1 : '0;
      run_armed_q <= w_in_run;
      if (state_q != ST_DRAIN) idx_q <= '0;
      else if (w_rd_xfer)      idx_q <= idx_q + 1'b1;
    end
  end

  assign imem_wr_en = imem_wr_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_wr_en = dmem_wr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign imem_ovf   = ovf_q;

endmodule
`default_nettype wire
